// File: rtl/accel_pkg.sv
// Shared opcode classes, instruction field layout and sequencer state encodings
// for the accelerator front end.
package accel_pkg;

    localparam int unsigned BUFFER_LEN  = 32;
    localparam int unsigned INSTR_WIDTH = 24;
    localparam int unsigned PC_W        = $clog2(BUFFER_LEN);
    localparam int unsigned OPC_W       = 6;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned FLG_W       = 3;
    localparam int unsigned CNT_W       = 16;

    localparam int unsigned OPC_MSB  = 23;
    localparam int unsigned OPC_LSB  = 18;
    localparam int unsigned SRCA_MSB = 17;
    localparam int unsigned SRCA_LSB = 13;
    localparam int unsigned SRCB_MSB = 12;
    localparam int unsigned SRCB_LSB = 8;
    localparam int unsigned DST_MSB  = 7;
    localparam int unsigned DST_LSB  = 3;
    localparam int unsigned FLG_MSB  = 2;
    localparam int unsigned FLG_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_NOP       = 6'd0;
    localparam logic [OPC_W-1:0] OP_MATMUL    = 6'd1;
    localparam logic [OPC_W-1:0] OP_LAST_EXEC = 6'd9;
    localparam logic [OPC_W-1:0] OP_HALT      = 6'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Field order matches the instruction word MSB to LSB.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [REG_W-1:0] dst;
        logic [FLG_W-1:0] flags;
    } cmd_t;

    function automatic logic is_exec_op(input logic [OPC_W-1:0] op);
        return (op >= OP_MATMUL) && (op <= OP_LAST_EXEC);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits a word into command fields and
// classifies its opcode.
import accel_pkg::*;

module instr_decoder (
    input  logic [INSTR_WIDTH-1:0] word,
    output cmd_t                   fields_c,
    output logic                   is_nop_c,
    output logic                   is_exec_c,
    output logic                   is_halt_c,
    output logic                   is_illegal_c
);

    always_comb begin
        fields_c.opcode = word[OPC_MSB:OPC_LSB];
        fields_c.src_a  = word[SRCA_MSB:SRCA_LSB];
        fields_c.src_b  = word[SRCB_MSB:SRCB_LSB];
        fields_c.dst    = word[DST_MSB:DST_LSB];
        fields_c.flags  = word[FLG_MSB:FLG_LSB];
    end

    assign is_nop_c     = (word[OPC_MSB:OPC_LSB] == OP_NOP);
    assign is_exec_c    = is_exec_op(word[OPC_MSB:OPC_LSB]);
    assign is_halt_c    = (word[OPC_MSB:OPC_LSB] == OP_HALT);
    assign is_illegal_c = ~(is_nop_c | is_exec_c | is_halt_c);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode front end: walks the instruction buffer, skips NOPs and issues
// decoded commands over valid/ready. SEQ_PERF_EN enables the issue/stall counters.
import accel_pkg::*;

module instr_sequencer (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [5:0]             cmd_opcode,
    output logic [4:0]             cmd_src_a,
    output logic [4:0]             cmd_src_b,
    output logic [4:0]             cmd_dst,
    output logic [2:0]             cmd_flags,
    output logic                   busy,
    output logic                   halted,
    output logic                   err_illegal,
    output logic [PC_W-1:0]        pc,
    output logic [CNT_W-1:0]       issue_count,
    output logic [CNT_W-1:0]       stall_cycles
);

    state_t            state, state_nxt;
    cmd_t              instr, instr_nxt;
    logic [PC_W-1:0]   pc_nxt, pc_inc;
    logic              err_nxt, valid_nxt, busy_nxt, halted_nxt;
    logic              handshake_c;

    cmd_t              dec_fields_c;
    logic              dec_is_nop_c, dec_is_exec_c, dec_is_halt_c, dec_is_illegal_c;

    instr_decoder u_dec (
        .word         (imem_rdata),
        .fields_c     (dec_fields_c),
        .is_nop_c     (dec_is_nop_c),
        .is_exec_c    (dec_is_exec_c),
        .is_halt_c    (dec_is_halt_c),
        .is_illegal_c (dec_is_illegal_c)
    );

    assign imem_addr   = pc;
    assign handshake_c = cmd_valid & cmd_ready;
    assign pc_inc      = (pc == PC_W'(BUFFER_LEN - 1)) ? '0 : pc + PC_W'(1);

    assign cmd_opcode = instr.opcode;
    assign cmd_src_a  = instr.src_a;
    assign cmd_src_b  = instr.src_b;
    assign cmd_dst    = instr.dst;
    assign cmd_flags  = instr.flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= '0;
            instr       <= '0;
            err_illegal <= 1'b0;
            cmd_valid   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            err_illegal <= err_nxt;
            cmd_valid   <= valid_nxt;
            busy        <= busy_nxt;
            halted      <= halted_nxt;
        end
    end

    // Next-state logic; status outputs are registered from the next state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        err_nxt   = err_illegal;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                instr_nxt = dec_fields_c;
                if (dec_is_nop_c) begin
                    pc_nxt    = pc_inc;
                    state_nxt = ST_FETCH;
                end else if (dec_is_exec_c) begin
                    state_nxt = ST_ISSUE;
                end else if (dec_is_halt_c || dec_is_illegal_c) begin
                    err_nxt   = dec_is_illegal_c;
                    state_nxt = ST_HALTED;
                end
            end
            ST_ISSUE: begin
                if (handshake_c) begin
                    pc_nxt    = pc_inc;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    err_nxt   = 1'b0;
                    pc_nxt    = '0;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        valid_nxt  = (state_nxt == ST_ISSUE);
        busy_nxt   = (state_nxt == ST_FETCH) || (state_nxt == ST_DECODE) ||
                     (state_nxt == ST_ISSUE);
        halted_nxt = (state_nxt == ST_HALTED);
    end

`ifdef SEQ_PERF_EN
    logic             restart_c, stall_c;
    logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;

    assign restart_c = start && ((state == ST_IDLE) || (state == ST_HALTED));
    assign stall_c   = (state == ST_ISSUE) && !cmd_ready;

    // Saturating performance counters, cleared on every (re)start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (restart_c) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (handshake_c && (issue_cnt_q != {CNT_W{1'b1}}))
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            if (stall_c && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign issue_count  = issue_cnt_q;
    assign stall_cycles = stall_cnt_q;
`else
    assign issue_count  = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs plus randomized
// programs checked against a walk-the-buffer reference model.
`timescale 1ns/1ps

module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, cmd_valid, cmd_ready, busy, halted, err_illegal;
    logic [4:0]  imem_addr, pc;
    logic [23:0] imem_rdata;
    logic [5:0]  cmd_opcode;
    logic [4:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic [2:0]  cmd_flags;
    logic [15:0] issue_count, stall_cycles;

    logic [23:0] mem [32];
    logic [23:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ready_mode = 0;
    int          hold_cnt = 0;
    int          stall_obs = 0;
    int          hs_count = 0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_cmd, mon_got, mon_exp;

    instr_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .cmd_dst      (cmd_dst),
        .cmd_flags    (cmd_flags),
        .busy         (busy),
        .halted       (halted),
        .err_illegal  (err_illegal),
        .pc           (pc),
        .issue_count  (issue_count),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    // Execute-stage ready: 0 always 1, 1 random, 2 hold low 5 valid cycles, 3 always 0.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = ($urandom_range(0, 99) < 60);
            2: begin
                if (cmd_valid) begin
                    cmd_ready = (hold_cnt >= 5);
                    hold_cnt++;
                end else begin
                    cmd_ready = 1'b0;
                end
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            mon_got = {cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst, cmd_flags};
            if (prev_stall) begin
                n_vec++;
                if (cmd_valid !== 1'b1 || mon_got !== prev_cmd) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%0b cmd=%h, required valid=1 cmd=%h",
                             cmd_valid, mon_got, prev_cmd);
                end
            end
            if (cmd_valid && cmd_ready) begin
                hs_count++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_cmd: got %h, required no command", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_err++;
                        $display("FAIL cmd_fields: got %h, required %h", mon_got, mon_exp);
                    end
                end
            end else if (cmd_valid) begin
                stall_obs++;
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_cmd   = mon_got;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int budget);
        int c = 0;
        while (halted !== 1'b1 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (halted !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: halted=%0b after %0d cycles, required 1", tag, halted, c);
        end
    endtask

    task automatic end_checks(input string tag, input int epc, input int eerr, input int ncmd);
        check({tag, "_halted"}, int'(halted), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(cmd_valid), 0);
        check({tag, "_pc"}, int'(pc), epc);
        check({tag, "_err"}, int'(err_illegal), eerr);
        check({tag, "_handshakes"}, hs_count, ncmd);
        check({tag, "_pending"}, exp_q.size(), 0);
`ifdef SEQ_PERF_EN
        check({tag, "_issue_count"}, int'(issue_count), ncmd);
        check({tag, "_stall_cycles"}, int'(stall_cycles), stall_obs);
`else
        check({tag, "_issue_count"}, int'(issue_count), 0);
        check({tag, "_stall_cycles"}, int'(stall_cycles), 0);
`endif
    endtask

    // Reference: walk the buffer from word 0 until HALT or an illegal opcode.
    task automatic model_run(output int epc, output int eerr);
        int p = 0;
        logic [5:0] op;
        epc  = 0;
        eerr = 0;
        for (int s = 0; s < 256; s++) begin
            op = mem[p][23:18];
            if (op == 6'd0) begin
                p = (p + 1) % 32;
            end else if (op <= 6'd9) begin
                exp_q.push_back(mem[p]);
                p = (p + 1) % 32;
            end else begin
                epc  = p;
                eerr = (op != 6'd10) ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic load_prog1();
        for (int i = 0; i < 32; i++) mem[i] = 24'h0;
        mem[4] = {6'd1, 5'd0, 5'd4, 5'd8, 3'd0};
        mem[7] = {6'd10, 18'd0};
    endtask

    task automatic new_run();
        hs_count  = 0;
        stall_obs = 0;
        hold_cnt  = 0;
    endtask

    initial begin
        int epc, eerr, n, h, r, c;
        logic [23:0] w;
        rst = 1'b1;
        start = 1'b0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 24'h0;
        #22;
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_err", int'(err_illegal), 0);
        check("rst_pc", int'(pc), 0);
        check("rst_fields", int'({cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst, cmd_flags}), 0);
        check("rst_counters", int'({issue_count, stall_cycles}), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single MATMUL then HALT at word 7, ready always high.
        load_prog1();
        ready_mode = 0;
        new_run();
        exp_q.push_back({6'd1, 5'd0, 5'd4, 5'd8, 3'd0});
        pulse_start();
        wait_halted("t1", 200);
        end_checks("t1", 7, 0, 1);

        // Same program with five stalled ISSUE cycles before the handshake.
        ready_mode = 2;
        new_run();
        exp_q.push_back({6'd1, 5'd0, 5'd4, 5'd8, 3'd0});
        pulse_start();
        wait_halted("t2", 200);
        end_checks("t2", 7, 0, 1);
        check("t2_stall_obs", stall_obs, 5);
`ifdef SEQ_PERF_EN
        check("t2_stall_cycles_5", int'(stall_cycles), 5);
`endif

        // Illegal opcode at word 0, then a restart clears the error.
        for (int i = 0; i < 32; i++) mem[i] = 24'h0;
        mem[0] = {6'd63, 18'd0};
        ready_mode = 0;
        new_run();
        pulse_start();
        wait_halted("t3", 200);
        end_checks("t3", 0, 1, 0);
        mem[0] = {6'd10, 18'd0};
        new_run();
        pulse_start();
        check("t3_restart_err", int'(err_illegal), 0);
        check("t3_restart_busy", int'(busy), 1);
        check("t3_restart_addr", int'(imem_addr), 0);
        wait_halted("t3b", 200);
        end_checks("t3b", 0, 0, 0);

        // PC wrap: EXEC at word 31, word 0 becomes HALT once the walk has passed it.
        for (int i = 0; i < 32; i++) mem[i] = 24'h0;
        w = 24'($urandom());
        mem[31] = {6'd2, w[17:0]};
        new_run();
        exp_q.push_back({6'd2, w[17:0]});
        pulse_start();
        c = 0;
        while (imem_addr !== 5'd5 && c < 100) begin @(posedge clk); #1; c++; end
        check("t4_reached_pc5", int'(imem_addr), 5);
        mem[0] = {6'd10, 18'd0};
        wait_halted("t4", 500);
        end_checks("t4", 0, 0, 1);

        // Randomized programs, random ready, spurious start pulses while busy.
        for (int t = 0; t < 20; t++) begin
            h = $urandom_range(4, 31);
            for (int i = 0; i < 32; i++) begin
                w = 24'($urandom());
                r = $urandom_range(0, 99);
                if (i > h)       mem[i] = w;
                else if (i == h) mem[i] = {6'd10, w[17:0]};
                else if (r < 45) mem[i] = {6'd0, w[17:0]};
                else if (r < 96) mem[i] = {6'($urandom_range(1, 9)), w[17:0]};
                else             mem[i] = {6'($urandom_range(11, 63)), w[17:0]};
            end
            new_run();
            model_run(epc, eerr);
            n = exp_q.size();
            ready_mode = 1;
            pulse_start();
            c = 0;
            while (halted !== 1'b1 && c < 2000) begin
                @(posedge clk); #1;
                start = busy && ($urandom_range(0, 7) == 0);
                c++;
            end
            start = 1'b0;
            if (halted !== 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL rand%0d_timeout: halted=%0b, required 1", t, halted);
            end
            end_checks($sformatf("rand%0d", t), epc, eerr, n);
        end

        // Asynchronous reset in the middle of a stalled ISSUE drops the command.
        load_prog1();
        ready_mode = 3;
        new_run();
        pulse_start();
        c = 0;
        while (cmd_valid !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
        check("t5_valid_seen", int'(cmd_valid), 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("t5_valid_async", int'(cmd_valid), 0);
        check("t5_pc_async", int'(pc), 0);
        check("t5_busy_async", int'(busy), 0);
        check("t5_halted_async", int'(halted), 0);
        @(posedge clk); #1 rst = 1'b0;
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_idle_busy", int'(busy), 0);
        check("t5_idle_valid", int'(cmd_valid), 0);
        check("t5_no_handshake", hs_count, 0);

        // Start from IDLE begins fetching on the next cycle.
        new_run();
        exp_q.push_back({6'd1, 5'd0, 5'd4, 5'd8, 3'd0});
        pulse_start();
        check("t6_busy", int'(busy), 1);
        check("t6_addr", int'(imem_addr), 0);
        wait_halted("t6", 200);
        end_checks("t6", 7, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
